// File: rtl/match_reporter_if.sv
// Upstream character stream and report-record handshake bundle for match_reporter.
// The slave modport is the reporter; the master modport is the table reader plus the consumer.
interface match_reporter_if #(
  parameter int POS_W = 16
);
  logic             en;
  logic [7:0]       now_state_in;
  logic             en_match;
  logic             eos;
  logic             busy;
  logic             report_valid;
  logic             report_ready;
  logic [3:0]       report_id;
  logic [POS_W-1:0] report_pos;
  logic             done;
  logic             overflow;
  logic [15:0]      match_count;

  modport master (
    output en, now_state_in, en_match, eos, report_ready,
    input  busy, report_valid, report_id, report_pos, done, overflow, match_count
  );

  modport slave (
    input  en, now_state_in, en_match, eos, report_ready,
    output busy, report_valid, report_id, report_pos, done, overflow, match_count
  );
endinterface

// File: rtl/match_reporter.sv
// Turns automaton states into {pattern ID, byte position} records in a show-ahead FIFO.
// Define MATCH_REPORTER_STATS_EN to build the saturating match_count counter.
module match_reporter #(
  parameter int           FIFO_DEPTH   = 8,
  parameter int           POS_W        = 16,
  parameter logic [127:0] OUTPUT_TABLE = '0
) (
  input logic            clk,
  input logic            rst,
  match_reporter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t           state;
  logic [3:0]       ram_output [32];
  logic [3:0]       id_mem [FIFO_DEPTH];
  logic [POS_W-1:0] pos_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [POS_W-1:0] pos;
  logic [3:0]       hit_id;
  logic             accept;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;

  // Entry i of the pattern-ID table lives in OUTPUT_TABLE[4*i +: 4]; ID 0 is non-accepting.
  for (genvar i = 0; i < 32; i++) begin : g_table
    assign ram_output[i] = OUTPUT_TABLE[4*i +: 4];
  end

  always_comb begin
    accept   = bus.en && (state != FLUSH);
    hit_id   = ram_output[bus.now_state_in[4:0]];
    push_req = accept && bus.en_match && (bus.now_state_in[7:5] == 3'b000) && (hit_id != 4'd0);
    pop      = (count != '0) && bus.report_ready;
    full     = (count == DEPTH_C);
    push_ok  = push_req && (!full || pop);
  end

  // Head fields read as zero whenever nothing is queued, so reset leaves clean outputs.
  assign bus.report_valid = (count != '0);
  assign bus.report_id    = (count != '0) ? id_mem[rd_ptr]  : 4'd0;
  assign bus.report_pos   = (count != '0) ? pos_mem[rd_ptr] : '0;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pos    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        pos <= bus.eos ? '0 : pos + POS_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= bus.eos ? FLUSH : SCAN;
            busy_q <= bus.eos;
          end
        end
        SCAN: begin
          if (accept && bus.eos) begin
            state  <= FLUSH;
            busy_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (count == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A full FIFO still takes a record when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count <= count - CNT_W'(1);
      end
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      id_mem[wr_ptr]  <= hit_id;
      pos_mem[wr_ptr] <= pos;
    end
  end

`ifdef MATCH_REPORTER_STATS_EN
  logic [15:0] match_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      match_count_q <= 16'd0;
    end else if (push_req && (match_count_q != 16'hFFFF)) begin
      match_count_q <= match_count_q + 16'd1;
    end
  end

  assign bus.match_count = match_count_q;
`else
  assign bus.match_count = 16'd0;
`endif
endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_match_reporter;
  localparam int DEPTH = 8;
  localparam int POS_W = 4;
`ifdef MATCH_REPORTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic logic [127:0] build_table();
    logic [127:0] t;
    t = '0;
    t[5*4  +: 4] = 4'h2;
    t[7*4  +: 4] = 4'hA;
    t[12*4 +: 4] = 4'h3;
    t[31*4 +: 4] = 4'hF;
    return t;
  endfunction

  localparam logic [127:0] TABLE = build_table();

  typedef struct packed {
    logic [3:0]       id;
    logic [POS_W-1:0] pos;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   cmp_on = 1'b0;

  rec_t             mq[$];
  bit               m_flush = 1'b0;
  bit               m_done = 1'b0;
  bit               m_ovf = 1'b0;
  logic [POS_W-1:0] m_pos = '0;
  int               m_cnt = 0;

  always #5 clk = ~clk;

  match_reporter_if #(.POS_W(POS_W)) bus();

  match_reporter #(
    .FIFO_DEPTH  (DEPTH),
    .POS_W       (POS_W),
    .OUTPUT_TABLE(TABLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [3:0] tbl_id(input logic [7:0] s);
    if (s >= 8'd32) return 4'h0;
    return TABLE[int'(s[4:0])*4 +: 4];
  endfunction

  // Reference behaviour: records queue up in arrival order, flush ends one cycle after the queue drains.
  always @(posedge clk) begin
    int   sz;
    bit   flushing;
    bit   do_pop;
    rec_t r;
    if (rst) begin
      mq.delete();
      m_flush = 1'b0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_pos   = '0;
      m_cnt   = 0;
    end else begin
      sz       = mq.size();
      flushing = m_flush;
      do_pop   = (sz > 0) && bus.report_ready;
      m_done   = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (!flushing && bus.en) begin
        if (bus.en_match && tbl_id(bus.now_state_in) != 4'h0) begin
          if (m_cnt < 65535) m_cnt++;
          if (sz < DEPTH || do_pop) begin
            r.id  = tbl_id(bus.now_state_in);
            r.pos = m_pos;
            mq.push_back(r);
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (bus.eos) begin
          m_pos   = '0;
          m_flush = 1'b1;
        end else begin
          m_pos = m_pos + 1'b1;
        end
      end else if (flushing && sz == 0) begin
        m_flush = 1'b0;
        m_done  = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("model_report_valid", 32'(bus.report_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        checkOutput("model_report_id", 32'(bus.report_id), 32'(mq[0].id));
        checkOutput("model_report_pos", 32'(bus.report_pos), 32'(mq[0].pos));
      end
      checkOutput("model_busy", 32'(bus.busy), 32'(m_flush));
      checkOutput("model_done", 32'(bus.done), 32'(m_done));
      checkOutput("model_overflow", 32'(bus.overflow), 32'(m_ovf));
      checkOutput("model_match_count", 32'(bus.match_count), STATS ? 32'(m_cnt) : 32'd0);
    end
  end

  task automatic applyStimulus(input bit en, input logic [7:0] st, input bit m, input bit e, input bit rdy);
    bus.en           = en;
    bus.now_state_in = st;
    bus.en_match     = m;
    bus.eos          = e;
    bus.report_ready = rdy;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.report_valid), 32'd0);
    checkOutput({tag, "_id"}, 32'(bus.report_id), 32'd0);
    checkOutput({tag, "_pos"}, 32'(bus.report_pos), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    checkOutput({tag, "_match_count"}, 32'(bus.match_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkResetState("reset");
    cmp_on = 1'b1;
    rst    = 1'b0;

    $display("[TB] single match at position 3");
    applyStimulus(1'b1, 8'd1,  1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd37, 1'b1, 1'b0, 1'b1);
    checkOutput("state_ge_32_no_match", 32'(bus.report_valid), 32'd0);
    applyStimulus(1'b1, 8'd12, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd5,  1'b1, 1'b1, 1'b1);
    checkOutput("s1_valid", 32'(bus.report_valid), 32'd1);
    checkOutput("s1_id", 32'(bus.report_id), 32'd2);
    checkOutput("s1_pos", 32'(bus.report_pos), 32'd3);
    checkOutput("s1_count", 32'(bus.match_count), 32'(STATS ? 1 : 0));
    checkOutput("s1_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_done_early", 32'(bus.done), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_done", 32'(bus.done), 32'd1);
    checkOutput("s1_busy_clear", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_done_pulse", 32'(bus.done), 32'd0);

    $display("[TB] accepting state without goto, eos straight from idle");
    doReset();
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b1, 1'b1);
    checkOutput("s2_valid", 32'(bus.report_valid), 32'd0);
    checkOutput("s2_busy", 32'(bus.busy), 32'd1);
    checkOutput("s2_count", 32'(bus.match_count), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s2_done", 32'(bus.done), 32'd1);

    $display("[TB] nine matches into an eight-deep fifo");
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("s3_overflow", 32'(bus.overflow), 32'd1);
    checkOutput("s3_count", 32'(bus.match_count), 32'(STATS ? 9 : 0));
    checkOutput("s3_head_id", 32'(bus.report_id), 32'hA);
    for (int i = 0; i < 8; i++) begin
      checkOutput("s3_drain_pos", 32'(bus.report_pos), 32'(i));
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("s3_empty", 32'(bus.report_valid), 32'd0);

    $display("[TB] push and pop together on a full fifo");
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_full_no_overflow", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 8'd12, 1'b1, 1'b0, 1'b1);
    checkOutput("s4_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("s4_head_pos", 32'(bus.report_pos), 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s4_last_id", 32'(bus.report_id), 32'd3);
    checkOutput("s4_last_pos", 32'(bus.report_pos), 32'd8);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s4_empty", 32'(bus.report_valid), 32'd0);

    $display("[TB] flush with two pending records and en held high");
    doReset();
    applyStimulus(1'b1, 8'd1,  1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd3,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd5,  1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd0,  1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd31, 1'b1, 1'b1, 1'b0);
    checkOutput("s5_busy", 32'(bus.busy), 32'd1);
    checkOutput("s5_head_pos", 32'(bus.report_pos), 32'd2);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("s5_en_ignored_count", 32'(bus.match_count), 32'(STATS ? 2 : 0));
    checkOutput("s5_en_ignored_id", 32'(bus.report_id), 32'd2);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    checkOutput("s5_second_id", 32'(bus.report_id), 32'hF);
    checkOutput("s5_second_pos", 32'(bus.report_pos), 32'd5);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    checkOutput("s5_drained_done", 32'(bus.done), 32'd0);
    checkOutput("s5_drained_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    checkOutput("s5_done", 32'(bus.done), 32'd1);
    checkOutput("s5_valid_after_done", 32'(bus.report_valid), 32'd0);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("s5_next_id", 32'(bus.report_id), 32'd2);
    checkOutput("s5_next_pos", 32'(bus.report_pos), 32'd0);

    $display("[TB] reset during flush");
    doReset();
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("s6_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    checkResetState("s6");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("s6_no_done", 32'(bus.done), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] position wrap");
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    checkOutput("s7_max_pos", 32'(bus.report_pos), 32'd15);
    applyStimulus(1'b1, 8'd12, 1'b1, 1'b0, 1'b1);
    checkOutput("s7_wrap_id", 32'(bus.report_id), 32'd3);
    checkOutput("s7_wrap_pos", 32'(bus.report_pos), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/match_reporter.md
MATCH_REPORTER -- requirements
Module: match_reporter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, record FIFO entries (power of two, >=2).
REQ-002 Parameter: POS_W, default 16, width of the byte-position field.
REQ-003 Ports: CLK  in  1  sole clock, all logic on rising edge.
REQ-004 Ports: RST  in  1  synchronous, active-high reset.
REQ-005 Ports: EN  in  1  one per processed character, paired with NOW_STATE_IN/EN_MATCH from the upstream table reader.
REQ-006 Ports: NOW_STATE_IN  in  8  automaton state reached after the character.
REQ-007 Ports: EN_MATCH  in  1  goto transition taken for the character.
REQ-008 Ports: EOS  in  1  qualified by EN, marks the last character of the string.
REQ-009 Ports: BUSY  out  1  high in FLUSH; upstream shall hold EN low.
REQ-010 Ports: REPORT_VALID  out  1  FIFO head valid.
REQ-011 Ports: REPORT_READY  in  1  consumer accepts head.
REQ-012 Ports: REPORT_ID  out  4  pattern ID of head record.
REQ-013 Ports: REPORT_POS  out  POS_W  position of the last byte of the match.
REQ-014 Ports: DONE  out  1  one-cycle pulse, string fully reported.
REQ-015 Ports: OVERFLOW  out  1  sticky, record dropped.
REQ-016 Ports: MATCH_COUNT  out  16  matches detected since reset.

Function
REQ-017 Output table RAM_OUTPUT[0:31] of 4-bit pattern IDs, loaded by $readmemh from "output_state.txt"; ID 0 means non-accepting.
REQ-018 Position counter POS: on an EN cycle the current POS is the character's position; POS then increments, wrapping from 2^POS_W-1 to 0, and clears to 0 instead when EOS=1.
REQ-019 A match is detected when EN=1, EN_MATCH=1, NOW_STATE_IN<32 and RAM_OUTPUT[NOW_STATE_IN]!=0; states >=32 never match.
REQ-020 A detected match pushes {ID, POS} into the FIFO; REPORT_VALID/ID/POS reflect it on the cycle after the EN cycle if the FIFO was empty (show-ahead FIFO, 1-cycle latency).
REQ-021 The head pops when REPORT_VALID && REPORT_READY; REPORT_* hold stable while VALID && !READY.
REQ-022 A push when full is accepted only if a pop happens in the same cycle; otherwise the record is dropped and OVERFLOW sets.
REQ-023 A pop on an empty FIFO has no effect; a simultaneous push and pop on an empty FIFO stores the push.
REQ-024 FSM IDLE: the first EN moves to SCAN, processing the character.
REQ-025 FSM SCAN: EN with EOS=1 moves to FLUSH after processing the character.
REQ-026 FSM FLUSH: BUSY=1 and EN is ignored (no push, no POS change); when the FIFO is empty, DONE pulses and the FSM returns to IDLE in the same cycle.
REQ-027 EN with EOS=1 in IDLE processes the character and goes directly to FLUSH.
REQ-028 MATCH_COUNT increments per detected match, including dropped ones, and saturates at 0xFFFF.

Reset
REQ-029 RST=1 at a clock edge: FSM=IDLE, POS=0, FIFO empty, REPORT_VALID=0, REPORT_ID=0, REPORT_POS=0, DONE=0, BUSY=0, OVERFLOW=0, MATCH_COUNT=0.
REQ-030 RST takes priority over every input in the same cycle, including mid-string or mid-flush; pending records are discarded and no DONE is issued.
REQ-031 RAM_OUTPUT contents are not affected by RST.

Configuration
REQ-032 Macro MATCH_REPORTER_STATS_EN, when defined, includes the MATCH_COUNT counter per REQ-028.
REQ-033 Without MATCH_REPORTER_STATS_EN, MATCH_COUNT is tied to 0 and no counter logic exists; all other behaviour is unchanged.

Verification
REQ-034 Table ID 2 at state 5; stream 4 characters with NOW_STATE_IN 5 at position 3, EN_MATCH=1, READY=1 -> one record {ID=2, POS=3} visible the next cycle, MATCH_COUNT=1.
REQ-035 Same state 5 with EN_MATCH=0 -> no record, MATCH_COUNT=0.
REQ-036 READY=0, 9 matches with FIFO_DEPTH=8 -> 8 records retained in order, OVERFLOW=1, MATCH_COUNT=9 (0 without the macro).
REQ-037 FIFO full, push and pop in the same cycle -> no drop, OVERFLOW stays 0, depth stays 8.
REQ-038 EOS on character 6 with 2 records pending; EN asserted during FLUSH -> BUSY=1, EN ignored, DONE pulses once the last record pops, next string starts at POS=0.
REQ-039 RST asserted in FLUSH with 3 records pending -> all outputs per REQ-029 on the next cycle, no DONE pulse.
